xorn_frame_checksum_v: RTL and testbench
========================================

Name: xorn_frame_checksum_v

Overview:
- Streaming, parametrised successor to the two-input XOR gate primitive.
- Folds a frame of WIDTH-bit words into one running XOR/XNOR checksum. Also produces the word-level parity and the frame word count.
- Input and output use valid/ready handshakes. The block sits between a word source and a result consumer in the datapath.
- One frame in flight at a time. The result is held until the consumer accepts it.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- MAX_WORDS, 15, largest legal frame length. Longer frames saturate the count and flag overflow.
- CW, $clog2(MAX_WORDS+1), derived localparam giving the width of o_count.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  synchronous, active-low reset
- i_valid  input  1  input word valid
- o_ready  output  1  block can accept an input word
- i_data  input  WIDTH  input word
- i_last  input  1  marks the final word of the frame
- i_mode  input  1  0 = XOR checksum, 1 = XNOR (inverted) checksum; sampled on the first word only
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts the result
- o_sum  output  WIDTH  frame checksum
- o_parity  output  1  XOR reduction of o_sum
- o_count  output  CW  words accepted in the frame, saturating at MAX_WORDS
- o_ovf  output  1  frame exceeded MAX_WORDS words

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of i_clk. Effects:
  - state = IDLE
  - acc = 0, count = 0, ovf = 0, mode = 0
  - o_valid = 0, o_ready = 1, o_sum = 0, o_parity = 0, o_count = 0, o_ovf = 0
  - Reset mid-frame discards all partial state; no result is produced.
- Accept condition: a word is accepted when i_valid && o_ready.
- o_ready = (state != DONE).
- While in DONE, i_valid is ignored and no word is consumed.
- State machine (2-bit state):
  - IDLE, on accept:
    - acc <= i_data; count <= 1; ovf <= 0; mode <= i_mode
    - go to DONE if i_last, else to ACCUM
  - ACCUM, on accept:
    - acc <= acc ^ i_data
    - if count == MAX_WORDS: count holds and ovf <= 1 (sticky until the next frame starts); else count <= count + 1
    - go to DONE if i_last
  - ACCUM, no accept: hold all state.
  - DONE:
    - o_valid = 1
    - on i_ready go to IDLE; acc, count and ovf keep their values until the next first-word accept.
- Output mapping (combinational from registers, valid in every state; meaningful only when o_valid = 1):
  - o_sum = mode ? ~acc : acc
  - o_parity = ^o_sum
  - o_count = count
  - o_ovf = ovf
- Latency: o_valid rises on the cycle after the i_last word is accepted.
- Throughput: an N-word frame takes N cycles plus at least one DONE cycle. A one-word frame is legal.
- Output stability: while o_valid && !i_ready, o_sum, o_parity, o_count and o_ovf are stable.
- i_mode changes after the first word are ignored.
- i_data and i_last are don't-care when i_valid = 0.

Decomposition:
- Shared package/include xorn_pkg:
  - state encodings: ST_IDLE = 2'd0, ST_ACCUM = 2'd1, ST_DONE = 2'd2
  - mode constants: MODE_XOR = 1'b0, MODE_XNOR = 1'b1
- One natural sub-module: xorn_word_v, parametrised by WIDTH. It is combinational and computes the bitwise XOR of two words plus the XOR reduction of its output. The top level instantiates it twice:
  - once for the accumulator update
  - once for parity
- FSM, counter and handshake logic stay in the top module.

Test Plan (WIDTH=8, MAX_WORDS=4):
- Reset: i_rst_n=0 for 2 cycles with i_valid=1, i_data=0xFF -> o_valid=0, o_ready=1, o_sum=0x00, o_count=0, o_ovf=0. No word is consumed.
- XOR frame: 0x0F, 0xF0, 0x3C (last on 0x3C), i_mode=0, i_ready=1 -> one cycle after the last accept: o_valid=1, o_sum=0xC3, o_parity=0, o_count=3, o_ovf=0. Back in IDLE one cycle later.
- XNOR single word: 0x01 with i_last=1, i_mode=1 -> o_sum=0xFE, o_parity=1, o_count=1. Toggling i_mode mid-frame in a 2-word frame has no effect on the result.
- Backpressure: frame 0xAA (last), then i_ready=0 for 3 cycles with i_valid=1, i_data=0x55 -> o_ready=0 and outputs held at 0xAA/1. After i_ready=1, next frame 0x55 (last) -> o_sum=0x55, o_count=1.
- Overflow: six words of 0x01, last on the 6th -> o_count=4, o_ovf=1, o_sum=0x00, o_parity=0. The following 1-word frame 0x02 -> o_ovf=0, o_sum=0x02.
- Reset mid-frame: accept 0x11, 0x22, then pulse i_rst_n=0 for one cycle -> no o_valid. Next frame 0x80 (last) -> o_sum=0x80, o_parity=1, o_count=1.

Source files
------------

// File: rtl/xorn_pkg.sv
// rtl/xorn_pkg.sv - shared state and mode encodings for the frame checksum block
//
// Purpose: state and mode encodings shared by the checksum top level and its bench.
// Ports:   none (package).
package xorn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } xorn_state_t;

  localparam logic MODE_XOR  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;

endpackage : xorn_pkg

// File: rtl/xorn_word_v.sv
// rtl/xorn_word_v.sv - combinational word XOR with reduction parity
//
// Purpose: bitwise XOR of two WIDTH-bit words plus the XOR reduction of the result.
// Ports:
//   i_a   [WIDTH-1:0] first operand
//   i_b   [WIDTH-1:0] second operand
//   o_y   [WIDTH-1:0] i_a ^ i_b
//   o_red             ^o_y
module xorn_word_v #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_red
);

  always_comb begin
    o_y   = i_a ^ i_b;
    o_red = ^o_y;
  end

endmodule : xorn_word_v

// File: rtl/xorn_frame_checksum_v.sv
// rtl/xorn_frame_checksum_v.sv - streaming XOR/XNOR frame checksum with parity and word count
//
// Purpose: folds a frame of WIDTH-bit words into one XOR (or XNOR) checksum, reporting
//          the checksum parity, the saturating word count and an overflow flag.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_valid/o_ready       input word handshake; i_data word, i_last end of frame,
//                         i_mode (0 XOR, 1 XNOR) sampled on the first word
//   o_valid/i_ready       result handshake
//   o_sum, o_parity       checksum and its XOR reduction
//   o_count, o_ovf        words in frame (saturating at MAX_WORDS), overflow flag
module xorn_frame_checksum_v
  import xorn_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 15,
  localparam int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_parity,
  output logic [CW-1:0]    o_count,
  output logic             o_ovf
);

  xorn_state_t      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;

  logic             accept;
  logic [WIDTH-1:0] acc_next;
  logic             acc_red_unused;
  logic [WIDTH-1:0] mode_mask;

  // Accumulator update: running checksum folded with the incoming word.
  xorn_word_v #(.WIDTH(WIDTH)) u_acc_word (
    .i_a   (acc_q),
    .i_b   (i_data),
    .o_y   (acc_next),
    .o_red (acc_red_unused)
  );

  // Output stage: XOR with an all-ones mask implements the XNOR inversion, and the
  // same instance's reduction yields the parity of the presented checksum.
  assign mode_mask = {WIDTH{mode_q == MODE_XNOR}};

  xorn_word_v #(.WIDTH(WIDTH)) u_out_word (
    .i_a   (acc_q),
    .i_b   (mode_mask),
    .o_y   (o_sum),
    .o_red (o_parity)
  );

  assign o_ready = (state_q != ST_DONE);
  assign o_valid = (state_q == ST_DONE);
  assign o_count = count_q;
  assign o_ovf   = ovf_q;
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = i_data;
          count_d = CW'(1);
          ovf_d   = 1'b0;
          mode_d  = i_mode;
          state_d = i_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_next;
          // Count saturates at MAX_WORDS; overflow stays set until the next frame.
          if (count_q == CW'(MAX_WORDS)) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
          if (i_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Result registers are left intact so they stay observable until the next frame.
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= MODE_XOR;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

endmodule : xorn_frame_checksum_v

// File: tb/tb_xorn_frame_checksum_v.sv
// tb/tb_xorn_frame_checksum_v.sv - self-checking bench for the frame checksum block
module tb_xorn_frame_checksum_v;

  localparam int W   = 8;
  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_data;
  logic          i_last;
  logic          i_mode;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_sum;
  logic          o_parity;
  logic [CW-1:0] o_count;
  logic          o_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xorn_frame_checksum_v #(.WIDTH(W), .MAX_WORDS(MAX)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_last   (i_last),
    .i_mode   (i_mode),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_sum    (o_sum),
    .o_parity (o_parity),
    .o_count  (o_count),
    .o_ovf    (o_ovf)
  );

  // Reference: checksum is the XOR of all words, inverted for XNOR frames; parity is
  // the odd/even count of ones; count is the word total clipped at MAX.
  function automatic logic [W+CW+1:0] model(input logic [W-1:0] w[$], input logic m);
    logic [W-1:0]  s;
    logic          p;
    logic [CW-1:0] c;
    logic          o;
    s = '0;
    foreach (w[i]) s = s ^ w[i];
    if (m) s = ~s;
    p = ($countones(s) % 2) == 1;
    c = (w.size() > MAX) ? CW'(MAX) : CW'(w.size());
    o = w.size() > MAX;
    return {s, p, c, o};
  endfunction

  // Presents one word at a negedge and returns at the negedge after the accepting edge.
  task automatic send_word(input logic [W-1:0] d, input logic last, input logic m);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    i_mode  = m;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = W'($urandom);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'hFF;
    i_last  = 1'b1;
    i_mode  = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({o_valid, o_ready, o_sum, o_parity, o_count, o_ovf} !== {1'b0, 1'b1, 8'h00, 1'b0, CW'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b sum=%h p=%b cnt=%0d ovf=%b, expected v=0 r=1 sum=00 p=0 cnt=0 ovf=0",
               o_valid, o_ready, o_sum, o_parity, o_count, o_ovf);
    end
    rst_n   = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({o_valid, o_count} !== {1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL reset_no_consume: got v=%b cnt=%0d, expected v=0 cnt=0", o_valid, o_count);
    end
  endtask

  task automatic test_xor_frame();
    send_word(8'h0F, 1'b0, 1'b0);
    send_word(8'hF0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b1, 1'b0);
    n_tests++;
    if ({o_valid, o_sum, o_parity, o_count, o_ovf} !== {1'b1, 8'hC3, 1'b0, CW'(3), 1'b0}) begin
      n_fail++;
      $display("FAIL xor_frame: got v=%b sum=%h p=%b cnt=%0d ovf=%b, expected v=1 sum=c3 p=0 cnt=3 ovf=0",
               o_valid, o_sum, o_parity, o_count, o_ovf);
    end
    @(negedge clk);
    n_tests++;
    if ({o_valid, o_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL xor_back_to_idle: got v=%b r=%b, expected v=0 r=1", o_valid, o_ready);
    end
  endtask

  task automatic test_xnor();
    send_word(8'h01, 1'b1, 1'b1);
    n_tests++;
    if ({o_valid, o_sum, o_parity, o_count} !== {1'b1, 8'hFE, 1'b1, CW'(1)}) begin
      n_fail++;
      $display("FAIL xnor_single: got v=%b sum=%h p=%b cnt=%0d, expected v=1 sum=fe p=1 cnt=1",
               o_valid, o_sum, o_parity, o_count);
    end
    @(negedge clk);
    send_word(8'h12, 1'b0, 1'b1);
    send_word(8'h34, 1'b1, 1'b0);
    n_tests++;
    if ({o_valid, o_sum, o_parity, o_count} !== {1'b1, 8'hD9, 1'b1, CW'(2)}) begin
      n_fail++;
      $display("FAIL xnor_mode_toggle: got v=%b sum=%h p=%b cnt=%0d, expected v=1 sum=d9 p=1 cnt=2",
               o_valid, o_sum, o_parity, o_count);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    send_word(8'hAA, 1'b1, 1'b0);
    i_valid = 1'b1;
    i_data  = 8'h55;
    i_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({o_valid, o_ready, o_sum, o_parity, o_count} !== {1'b1, 1'b0, 8'hAA, 1'b0, CW'(1)}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got v=%b r=%b sum=%h p=%b cnt=%0d, expected v=1 r=0 sum=aa p=0 cnt=1",
                 k, o_valid, o_ready, o_sum, o_parity, o_count);
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    send_word(8'h55, 1'b1, 1'b0);
    n_tests++;
    if ({o_valid, o_sum, o_count} !== {1'b1, 8'h55, CW'(1)}) begin
      n_fail++;
      $display("FAIL backpressure_next: got v=%b sum=%h cnt=%0d, expected v=1 sum=55 cnt=1",
               o_valid, o_sum, o_count);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 6; k++) send_word(8'h01, k == 5, 1'b0);
    n_tests++;
    if ({o_valid, o_sum, o_parity, o_count, o_ovf} !== {1'b1, 8'h00, 1'b0, CW'(MAX), 1'b1}) begin
      n_fail++;
      $display("FAIL overflow: got v=%b sum=%h p=%b cnt=%0d ovf=%b, expected v=1 sum=00 p=0 cnt=4 ovf=1",
               o_valid, o_sum, o_parity, o_count, o_ovf);
    end
    @(negedge clk);
    send_word(8'h02, 1'b1, 1'b0);
    n_tests++;
    if ({o_valid, o_sum, o_count, o_ovf} !== {1'b1, 8'h02, CW'(1), 1'b0}) begin
      n_fail++;
      $display("FAIL overflow_clear: got v=%b sum=%h cnt=%0d ovf=%b, expected v=1 sum=02 cnt=1 ovf=0",
               o_valid, o_sum, o_count, o_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if ({o_valid, o_ready, o_count} !== {1'b0, 1'b1, CW'(0)}) begin
      n_fail++;
      $display("FAIL midreset_state: got v=%b r=%b cnt=%0d, expected v=0 r=1 cnt=0", o_valid, o_ready, o_count);
    end
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_result: got v=%b, expected v=0", o_valid);
    end
    send_word(8'h80, 1'b1, 1'b0);
    n_tests++;
    if ({o_valid, o_sum, o_parity, o_count} !== {1'b1, 8'h80, 1'b1, CW'(1)}) begin
      n_fail++;
      $display("FAIL midreset_next: got v=%b sum=%h p=%b cnt=%0d, expected v=1 sum=80 p=1 cnt=1",
               o_valid, o_sum, o_parity, o_count);
    end
    @(negedge clk);
  endtask

  task automatic test_random_frames();
    logic [W-1:0]    words[$];
    logic            m;
    logic [W+CW+1:0] exp;
    int              n;
    int              stall;
    for (int f = 0; f < 30; f++) begin
      words.delete();
      n = $urandom_range(1, 7);
      m = 1'($urandom);
      for (int i = 0; i < n; i++) words.push_back(W'($urandom));
      exp = model(words, m);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          i_data = W'($urandom);
          i_last = 1'($urandom);
          @(negedge clk);
        end
        send_word(words[i], i == n - 1, (i == 0) ? m : 1'($urandom));
      end
      n_tests++;
      if ({o_valid, o_sum, o_parity, o_count, o_ovf} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL random_frame[%0d]: got v=%b sum=%h p=%b cnt=%0d ovf=%b, expected v=1 sum=%h p=%b cnt=%0d ovf=%b",
                 f, o_valid, o_sum, o_parity, o_count, o_ovf,
                 exp[W+CW+1:CW+2], exp[CW+1], exp[CW:1], exp[0]);
      end
      stall = $urandom_range(0, 3);
      if (stall > 0) begin
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = W'($urandom);
        repeat (stall) @(negedge clk);
        i_valid = 1'b0;
        n_tests++;
        if ({o_valid, o_ready, o_sum, o_parity, o_count, o_ovf} !== {1'b1, 1'b0, exp}) begin
          n_fail++;
          $display("FAIL random_stall[%0d]: got v=%b r=%b sum=%h cnt=%0d, expected held result with r=0",
                   f, o_valid, o_ready, o_sum, o_count);
        end
        i_ready = 1'b1;
      end
      @(negedge clk);
      n_tests++;
      if ({o_valid, o_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL random_release[%0d]: got v=%b r=%b, expected v=0 r=1", f, o_valid, o_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_xor_frame();
    test_xnor();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_xorn_frame_checksum_v
